frame_buffer_ctrl: RTL and testbench
====================================

Name: frame_buffer_ctrl

Overview:
Ping-pong frame-buffer write scheduler that feeds the HUB75 panel driver's dual-port RAM. It accepts 54-bit pixel lines from a host stream with a valid/ready handshake and generates the RAM write port signals (wr, addrWrite, dataLine). It owns the bank selects for both RAM ports and swaps banks only at a panel frame boundary, once a full frame is loaded and the minimum display dwell (RamTime) has expired. It drives requireData to the host.

Parameters:
DATA_W, 54, width of one RAM line / stream word
ADDR_W, 12, RAM write address width per bank
FRAME_WORDS, 3240, lines per frame (162 per row x 20 rows); must be <= 2**ADDR_W
TIME_W, 30, width of dwell time input and timer

Ports:
i_clk  in  1  system clock, all logic on rising edge
i_rst_n  in  1  reset, asynchronous, active-low
i_ram_time  in  TIME_W  minimum display dwell per frame, in i_clk cycles; sampled at reload
i_frame_end  in  1  one-cycle pulse from panel driver when the last row of a frame finishes (row-select wrap)
s_valid  in  1  host word valid
s_data  in  DATA_W  host pixel line
s_ready  out  1  controller accepts a word this cycle
o_wr  out  1  RAM write strobe
o_addr_write  out  ADDR_W  RAM write address within write bank
o_data_line  out  DATA_W  RAM write data
o_wr_bank  out  1  bank written by host
o_rd_bank  out  1  bank displayed by panel driver; always ~o_wr_bank
o_require_data  out  1  high while controller wants the next frame
o_swap  out  1  one-cycle pulse on bank swap
o_underrun  out  1  one-cycle pulse: frame boundary with dwell expired but frame not fully loaded
o_led  out  1  toggles on every swap

Behaviour:
- Reset (async assert, sync release): state=LOAD, wr_ptr=0, o_wr=0, o_addr_write=0, o_data_line=0, o_wr_bank=1, o_rd_bank=0, o_require_data=1, o_swap=0, o_underrun=0, o_led=0, timer=i_ram_time.
- States: LOAD, FULL.
- LOAD: s_ready=1 (combinational, state==LOAD). Accept = s_valid & s_ready.
  - On accept: next cycle o_wr=1, o_addr_write=wr_ptr, o_data_line=s_data (registered, 1-cycle latency); wr_ptr+1.
  - Accept with wr_ptr==FRAME_WORDS-1: wr_ptr<=0, state<=FULL, o_require_data<=0.
  - No accept: o_wr=0; o_addr_write and o_data_line hold.
- FULL: s_ready=0; o_wr=0 except the final write's cycle (first FULL cycle).
- Dwell timer: decrements by 1 every cycle in both states, saturates at 0; reloaded from i_ram_time on swap.
- Swap condition: state==FULL & timer==0 & i_frame_end. Next cycle: o_wr_bank and o_rd_bank toggle, o_swap=1 for one cycle, o_led toggles, timer=i_ram_time, state=LOAD, o_require_data=1.
- i_frame_end while FULL with timer>0: ignored, no swap.
- i_frame_end while LOAD with timer==0: no swap, o_underrun=1 for one cycle; display keeps the old bank.
- i_frame_end while LOAD with timer>0: ignored.
- Final word accepted in the same cycle as i_frame_end: no swap. State is still LOAD that cycle, so an underrun pulse fires if timer==0. Swap happens at the next qualifying i_frame_end.
- i_ram_time==0: swap on first i_frame_end after FULL.
- Bank switch happens after the final write. The final o_wr cycle uses the pre-swap o_wr_bank.
- i_ram_time is not re-sampled mid-dwell.
- Reset mid-load discards the partial frame; banks return to wr=1/rd=0.

Test Plan:
- Reset, then hold i_rst_n low mid-LOAD with wr_ptr=100 -> all outputs at reset values immediately, o_wr_bank=1, o_require_data=1.
- Stream 3240 words (s_data=index) with s_valid held, i_ram_time=0 -> o_wr pulses 3240 cycles, o_addr_write 0..3239 one cycle after each accept, s_ready=0 and o_require_data=0 the cycle after the 3240th accept.
- FULL, i_ram_time=50, pulse i_frame_end at cycle 20 and cycle 60 after reload -> no swap at 20; swap at 60: o_swap=1 one cycle, o_rd_bank 0->1, o_led=1, s_ready=1.
- Only 1000 words loaded, timer expired, pulse i_frame_end -> o_underrun=1 one cycle, no bank change, loading continues from address 1000.
- Random s_valid gaps (50% duty) over a full frame -> exactly 3240 writes, no address skips or duplicates, data matches accepted words.
- Last accept coincident with i_frame_end, timer=0 -> no swap that cycle, o_underrun=1, swap on next i_frame_end.

Source files
------------

// File: rtl/frame_buffer_ctrl.sv
// Ping-pong frame-buffer write scheduler: registers host lines into the RAM write
// port and swaps banks at a panel frame boundary once the frame is loaded and the dwell has expired.
module frame_buffer_ctrl #(
  parameter int DATA_W      = 54,
  parameter int ADDR_W      = 12,
  parameter int FRAME_WORDS = 3240,
  parameter int TIME_W      = 30
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [TIME_W-1:0] i_ram_time,
  input  logic              i_frame_end,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              o_wr,
  output logic [ADDR_W-1:0] o_addr_write,
  output logic [DATA_W-1:0] o_data_line,
  output logic              o_wr_bank,
  output logic              o_rd_bank,
  output logic              o_require_data,
  output logic              o_swap,
  output logic              o_underrun,
  output logic              o_led,
  output logic              o_state_dbg
);

  // Handshake: a word transfers on every rising edge where s_valid && s_ready.
  // s_ready depends only on state, never on s_valid.
  typedef enum logic {ST_LOAD = 1'b0, ST_FULL = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(FRAME_WORDS - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [TIME_W-1:0]   r_timer;
  logic                r_wr_bank;
  logic                w_accept;
  logic                w_last;
  logic                w_timer_zero;
  logic                w_swap;
  logic                w_underrun;

  assign s_ready        = (r_state == ST_LOAD);
  assign w_accept       = s_valid & s_ready;
  assign w_last         = (r_wr_ptr == LAST_PTR);
  assign w_timer_zero   = (r_timer == '0);
  assign w_swap         = (r_state == ST_FULL) & w_timer_zero & i_frame_end;
  assign w_underrun     = (r_state == ST_LOAD) & w_timer_zero & i_frame_end;
  assign o_require_data = (r_state == ST_LOAD);
  assign o_wr_bank      = r_wr_bank;
  assign o_rd_bank      = ~r_wr_bank;
  assign o_state_dbg    = r_state;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD: if (w_accept && w_last) w_state_nxt = ST_FULL;
      ST_FULL: if (w_swap)             w_state_nxt = ST_LOAD;
      default:                         w_state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_LOAD;
    else          r_state <= w_state_nxt;
  end

  // Write port: one-cycle registered copy of each accepted word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr     <= '0;
      o_wr         <= 1'b0;
      o_addr_write <= '0;
      o_data_line  <= '0;
    end else begin
      o_wr <= w_accept;
      if (w_accept) begin
        o_addr_write <= r_wr_ptr;
        o_data_line  <= s_data;
        r_wr_ptr     <= w_last ? '0 : r_wr_ptr + 1'b1;
      end
    end
  end

  // Dwell timer reloads only on a swap, so a changing i_ram_time mid-dwell has no effect.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_timer    <= i_ram_time;
      r_wr_bank  <= 1'b1;
      o_swap     <= 1'b0;
      o_underrun <= 1'b0;
      o_led      <= 1'b0;
    end else begin
      o_swap     <= w_swap;
      o_underrun <= w_underrun;
      if (w_swap) begin
        r_timer   <= i_ram_time;
        r_wr_bank <= ~r_wr_bank;
        o_led     <= ~o_led;
      end else if (!w_timer_zero) begin
        r_timer <= r_timer - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Directed bench for frame_buffer_ctrl: reset, full-rate load, dwell-gated swap,
// underrun, random valid gaps and a final word coincident with the frame boundary.
module tb_frame_buffer_ctrl;
  localparam int DATA_W      = 54;
  localparam int ADDR_W      = 12;
  localparam int FRAME_WORDS = 3240;
  localparam int TIME_W      = 30;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic [TIME_W-1:0] i_ram_time = '0;
  logic              i_frame_end = 1'b0;
  logic              s_valid = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_ready;
  logic              o_wr;
  logic [ADDR_W-1:0] o_addr_write;
  logic [DATA_W-1:0] o_data_line;
  logic              o_wr_bank;
  logic              o_rd_bank;
  logic              o_require_data;
  logic              o_swap;
  logic              o_underrun;
  logic              o_led;
  logic              o_state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  logic exp_wr_bank = 1'b1;
  logic exp_led     = 1'b0;
  logic [DATA_W-1:0] exp_q[$];

  frame_buffer_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FRAME_WORDS(FRAME_WORDS), .TIME_W(TIME_W)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ram_time(i_ram_time), .i_frame_end(i_frame_end),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .o_wr(o_wr), .o_addr_write(o_addr_write), .o_data_line(o_data_line),
    .o_wr_bank(o_wr_bank), .o_rd_bank(o_rd_bank), .o_require_data(o_require_data),
    .o_swap(o_swap), .o_underrun(o_underrun), .o_led(o_led), .o_state_dbg(o_state_dbg)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; s_valid = 1'b0; i_frame_end = 1'b0; i_ram_time = '0; s_data = '0;
    repeat (2) step();
    n_checks++; if (o_wr !== 1'b0) $display("FAIL reset_wr got %0h want 0", o_wr); else n_pass++;
    n_checks++; if (o_addr_write !== '0) $display("FAIL reset_addr got %0h want 0", o_addr_write); else n_pass++;
    n_checks++; if (o_data_line !== '0) $display("FAIL reset_data got %0h want 0", o_data_line); else n_pass++;
    n_checks++; if (o_wr_bank !== 1'b1 || o_rd_bank !== 1'b0)
      $display("FAIL reset_banks got wr=%0h rd=%0h want wr=1 rd=0", o_wr_bank, o_rd_bank); else n_pass++;
    n_checks++; if (o_require_data !== 1'b1 || s_ready !== 1'b1)
      $display("FAIL reset_req got req=%0h rdy=%0h want 1 1", o_require_data, s_ready); else n_pass++;
    n_checks++; if (o_swap !== 1'b0 || o_underrun !== 1'b0 || o_led !== 1'b0 || o_state_dbg !== 1'b0)
      $display("FAIL reset_flags got swap=%0h und=%0h led=%0h st=%0h want 0", o_swap, o_underrun, o_led, o_state_dbg);
    else n_pass++;
    @(negedge i_clk) i_rst_n = 1'b1;
    step();
    s_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      s_data = DATA_W'(k + 5);
      step();
    end
    s_valid = 1'b0;
    n_checks++; if (o_wr !== 1'b1 || o_addr_write !== 12'd99 || o_data_line !== 54'd104)
      $display("FAIL midload_write got wr=%0h addr=%0d data=%0d want 1 99 104", o_wr, o_addr_write, o_data_line);
    else n_pass++;
    #2 i_rst_n = 1'b0;
    #1;
    n_checks++; if (o_wr !== 1'b0 || o_addr_write !== '0 || o_data_line !== '0)
      $display("FAIL async_reset_port got wr=%0h addr=%0d data=%0h want 0 0 0", o_wr, o_addr_write, o_data_line);
    else n_pass++;
    n_checks++; if (o_wr_bank !== 1'b1 || o_rd_bank !== 1'b0 || o_require_data !== 1'b1)
      $display("FAIL async_reset_bank got wr=%0h rd=%0h req=%0h want 1 0 1", o_wr_bank, o_rd_bank, o_require_data);
    else n_pass++;
    @(negedge i_clk) i_rst_n = 1'b1;
    step();
  endtask

  task automatic test_full_frame();
    logic [DATA_W-1:0] exp_d;
    s_valid = 1'b1;
    for (int k = 0; k < FRAME_WORDS; k++) begin
      exp_d = DATA_W'(k);
      s_data = exp_d;
      n_checks++; if (s_ready !== 1'b1) $display("FAIL full_ready k=%0d got %0h want 1", k, s_ready); else n_pass++;
      step();
      n_checks++; if (o_wr !== 1'b1 || o_addr_write !== ADDR_W'(k) || o_data_line !== exp_d)
        $display("FAIL full_write k=%0d got wr=%0h addr=%0d data=%0d want 1 %0d %0d", k, o_wr, o_addr_write, o_data_line, k, k);
      else n_pass++;
    end
    s_valid = 1'b0;
    n_checks++; if (s_ready !== 1'b0 || o_require_data !== 1'b0 || o_state_dbg !== 1'b1)
      $display("FAIL full_state got rdy=%0h req=%0h st=%0h want 0 0 1", s_ready, o_require_data, o_state_dbg);
    else n_pass++;
    n_checks++; if (o_wr_bank !== 1'b1) $display("FAIL full_lastbank got %0h want 1", o_wr_bank); else n_pass++;
    step();
    n_checks++; if (o_wr !== 1'b0 || o_swap !== 1'b0)
      $display("FAIL full_idle got wr=%0h swap=%0h want 0 0", o_wr, o_swap); else n_pass++;
  endtask

  task automatic check_swap(input string name);
    exp_wr_bank = ~exp_wr_bank;
    exp_led     = ~exp_led;
    n_checks++; if (o_swap !== 1'b1 || o_wr_bank !== exp_wr_bank || o_rd_bank !== ~exp_wr_bank || o_led !== exp_led)
      $display("FAIL %s got swap=%0h wr=%0h rd=%0h led=%0h want 1 %0h %0h %0h", name, o_swap, o_wr_bank, o_rd_bank,
               o_led, exp_wr_bank, ~exp_wr_bank, exp_led);
    else n_pass++;
    n_checks++; if (s_ready !== 1'b1 || o_require_data !== 1'b1)
      $display("FAIL %s_ready got rdy=%0h req=%0h want 1 1", name, s_ready, o_require_data); else n_pass++;
  endtask

  task automatic test_dwell();
    // swap from a zero dwell, loading 3300 for the next dwell
    i_ram_time = 30'd3300;
    i_frame_end = 1'b1;
    step();
    i_frame_end = 1'b0;
    check_swap("dwell_swap0");
    i_ram_time = '0;
    s_valid = 1'b1;
    for (int k = 0; k < FRAME_WORDS; k++) begin
      s_data = DATA_W'(k ^ 'h155);
      step();
      if (k == 0) begin
        n_checks++; if (o_swap !== 1'b0 || o_addr_write !== '0)
          $display("FAIL dwell_swap_pulse got swap=%0h addr=%0d want 0 0", o_swap, o_addr_write); else n_pass++;
      end
    end
    s_valid = 1'b0;
    repeat (39) step();
    i_frame_end = 1'b1;
    step();
    i_frame_end = 1'b0;
    n_checks++; if (o_swap !== 1'b0 || o_wr_bank !== exp_wr_bank)
      $display("FAIL dwell_early got swap=%0h wr=%0h want 0 %0h", o_swap, o_wr_bank, exp_wr_bank); else n_pass++;
    repeat (19) step();
    i_frame_end = 1'b1;
    step();
    n_checks++; if (o_swap !== 1'b0 || o_underrun !== 1'b0 || o_state_dbg !== 1'b1)
      $display("FAIL dwell_timer1 got swap=%0h und=%0h st=%0h want 0 0 1", o_swap, o_underrun, o_state_dbg); else n_pass++;
    step();
    i_frame_end = 1'b0;
    check_swap("dwell_swap1");
    step();
    n_checks++; if (o_swap !== 1'b0) $display("FAIL dwell_one_cycle got %0h want 0", o_swap); else n_pass++;
  endtask

  task automatic test_underrun();
    logic [DATA_W-1:0] exp_d;
    s_valid = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      s_data = DATA_W'(k + 'h1000);
      step();
    end
    s_valid = 1'b0;
    i_frame_end = 1'b1;
    step();
    i_frame_end = 1'b0;
    n_checks++; if (o_underrun !== 1'b1 || o_swap !== 1'b0 || o_wr_bank !== exp_wr_bank || o_wr !== 1'b0)
      $display("FAIL underrun_pulse got und=%0h swap=%0h wr_bank=%0h wr=%0h want 1 0 %0h 0", o_underrun, o_swap,
               o_wr_bank, o_wr, exp_wr_bank);
    else n_pass++;
    step();
    n_checks++; if (o_underrun !== 1'b0) $display("FAIL underrun_one_cycle got %0h want 0", o_underrun); else n_pass++;
    s_valid = 1'b1;
    for (int k = 1000; k < FRAME_WORDS; k++) begin
      exp_d = DATA_W'(k + 'h1000);
      s_data = exp_d;
      step();
      n_checks++; if (o_wr !== 1'b1 || o_addr_write !== ADDR_W'(k) || o_data_line !== exp_d)
        $display("FAIL underrun_resume k=%0d got wr=%0h addr=%0d data=%0h want 1 %0d %0h", k, o_wr, o_addr_write,
                 o_data_line, k, exp_d);
      else n_pass++;
    end
    s_valid = 1'b0;
    i_frame_end = 1'b1;
    step();
    i_frame_end = 1'b0;
    check_swap("underrun_swap");
  endtask

  task automatic test_random_gaps();
    int accepted = 0;
    int writes = 0;
    int cyc = 0;
    logic last_acc = 1'b0;
    logic [63:0] d;
    logic [DATA_W-1:0] exp_d;
    logic [ADDR_W-1:0] exp_addr = '0;
    exp_q.delete();
    while (accepted < FRAME_WORDS && cyc < 20000) begin
      s_valid = ($urandom_range(0, 1) == 1);
      d = {$urandom, $urandom};
      s_data = d[DATA_W-1:0];
      last_acc = s_valid;
      if (s_valid) begin
        exp_q.push_back(s_data);
        accepted++;
      end
      step();
      cyc++;
      n_checks++; if (o_wr !== last_acc) $display("FAIL rand_wr cyc=%0d got %0h want %0h", cyc, o_wr, last_acc); else n_pass++;
      if (last_acc) begin
        writes++;
        exp_d = exp_q.pop_front();
        n_checks++; if (o_addr_write !== exp_addr || o_data_line !== exp_d)
          $display("FAIL rand_write got addr=%0d data=%0h want %0d %0h", o_addr_write, o_data_line, exp_addr, exp_d);
        else n_pass++;
        exp_addr++;
      end
    end
    s_valid = 1'b0;
    n_checks++; if (accepted != FRAME_WORDS || writes != FRAME_WORDS)
      $display("FAIL rand_count got acc=%0d writes=%0d want %0d", accepted, writes, FRAME_WORDS); else n_pass++;
    n_checks++; if (s_ready !== 1'b0 || o_require_data !== 1'b0)
      $display("FAIL rand_full got rdy=%0h req=%0h want 0 0", s_ready, o_require_data); else n_pass++;
    i_frame_end = 1'b1;
    step();
    i_frame_end = 1'b0;
    check_swap("rand_swap");
  endtask

  task automatic test_back_to_back();
    s_valid = 1'b1;
    for (int k = 0; k < FRAME_WORDS - 1; k++) begin
      s_data = DATA_W'(k);
      step();
    end
    s_data = DATA_W'(FRAME_WORDS - 1);
    i_frame_end = 1'b1;
    step();
    s_valid = 1'b0;
    i_frame_end = 1'b0;
    n_checks++; if (o_wr !== 1'b1 || o_addr_write !== LAST_ADDR || o_wr_bank !== exp_wr_bank)
      $display("FAIL b2b_last got wr=%0h addr=%0d bank=%0h want 1 %0d %0h", o_wr, o_addr_write, o_wr_bank,
               LAST_ADDR, exp_wr_bank);
    else n_pass++;
    n_checks++; if (o_swap !== 1'b0 || o_underrun !== 1'b1 || o_require_data !== 1'b0)
      $display("FAIL b2b_flags got swap=%0h und=%0h req=%0h want 0 1 0", o_swap, o_underrun, o_require_data); else n_pass++;
    step();
    n_checks++; if (o_underrun !== 1'b0 || o_swap !== 1'b0 || o_wr !== 1'b0)
      $display("FAIL b2b_after got und=%0h swap=%0h wr=%0h want 0 0 0", o_underrun, o_swap, o_wr); else n_pass++;
    i_frame_end = 1'b1;
    step();
    i_frame_end = 1'b0;
    check_swap("b2b_swap");
    step();
    n_checks++; if (o_swap !== 1'b0) $display("FAIL b2b_one_cycle got %0h want 0", o_swap); else n_pass++;
  endtask

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  initial begin
    test_reset();
    test_full_frame();
    test_dwell();
    test_underrun();
    test_random_gaps();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
